uart_rx_fifo: RTL

//  Receive-side byte buffer between the UART receiver and the Wishbone UART register block.
//  - Accepts one-cycle o_valid/o_data/o_error pulses from the receiver.
//  - Queues bytes in a show-ahead FIFO and reports level plus sticky error flags.
//  - The register block pops one byte per RDR read, so back-to-back characters no longer overwrite the single RDR.

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-register-block connection for the UART receive FIFO.
// The master side drives the push/pop/flag controls and the slave (FIFO) side returns status.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic             i_wr_valid;
    logic [WIDTH-1:0] i_wr_data;
    logic             i_frame_err;
    logic             i_rd_pop;
    logic             i_clr_err;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_rd_valid;
    logic [LW-1:0]    o_level;
    logic             o_full;
    logic             o_overflow;
    logic             o_frame_err;
    logic             o_irq;

    modport master (
        output i_wr_valid, i_wr_data, i_frame_err, i_rd_pop, i_clr_err,
        input  o_rd_data, o_rd_valid, o_level, o_full, o_overflow, o_frame_err, o_irq
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_frame_err, i_rd_pop, i_clr_err,
        output o_rd_data, o_rd_valid, o_level, o_full, o_overflow, o_frame_err, o_irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with level, sticky overflow/framing flags and interrupt request.
// Define UART_RX_FIFO_IRQ_EN to build the threshold/idle-timeout interrupt; otherwise o_irq is 0.
module uart_rx_fifo #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned IRQ_THRESH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20832
) (
    input logic            clk,
    input logic            reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_THRESH < 1 || IRQ_THRESH > DEPTH ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_rx_fifo: illegal parameter set");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level, level_next;
    logic             overflow, overflow_next;
    logic             frame_err, frame_err_next;
    logic             empty, full, push_ok, pop_ok;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A pop frees the slot in the same cycle, so a push into a full FIFO with a pop is accepted.
    always_comb begin
        pop_ok         = bus.i_rd_pop && !empty;
        push_ok        = bus.i_wr_valid && (!full || bus.i_rd_pop);
        level_next     = level;
        overflow_next  = overflow;
        frame_err_next = frame_err;
        if (push_ok && !pop_ok)
            level_next = level + 1'b1;
        else if (pop_ok && !push_ok)
            level_next = level - 1'b1;
        if (bus.i_wr_valid && full && !bus.i_rd_pop)
            overflow_next = 1'b1;
        else if (bus.i_clr_err)
            overflow_next = 1'b0;
        if (bus.i_frame_err)
            frame_err_next = 1'b1;
        else if (bus.i_clr_err)
            frame_err_next = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level     <= level_next;
            overflow  <= overflow_next;
            frame_err <= frame_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.i_wr_data;
    end

    assign bus.o_rd_data   = empty ? '0 : mem[rd_ptr];
    assign bus.o_rd_valid  = !empty;
    assign bus.o_level     = level;
    assign bus.o_full      = full;
    assign bus.o_overflow  = overflow;
    assign bus.o_frame_err = frame_err;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idle, idle_next;
    logic          irq;

    always_comb begin
        idle_next = idle;
        if (bus.i_wr_valid || level_next == '0)
            idle_next = '0;
        else if (idle != IW'(TIMEOUT_CYCLES))
            idle_next = idle + 1'b1;
    end

    // Built from next-state terms so o_irq lines up with o_level and the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle <= '0;
            irq  <= 1'b0;
        end else begin
            idle <= idle_next;
            irq  <= (level_next >= LW'(IRQ_THRESH)) | overflow_next | frame_err_next |
                    (idle_next == IW'(TIMEOUT_CYCLES));
        end
    end

    assign bus.o_irq = irq;
`else
    assign bus.o_irq = 1'b0;
`endif
endmodule
